fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 8'h00, PC loaded on reset.
REQ-002 Parameter HALT_OPC, default 4'hF, opcode (instr[15:12]) that stops fetch.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_addr  output  8  instruction-memory address, driven from the PC register.
REQ-006 imem_req  output  1  read request; data returns exactly one cycle later.
REQ-007 imem_rdata  input  16  instruction word for the request of the previous cycle.
REQ-008 br_taken  input  1  redirect from execute stage.
REQ-009 br_target  input  8  redirect address, sampled when br_taken=1.
REQ-010 id_ready  input  1  decode accepts an instruction this cycle.
REQ-011 if_valid  output  1  if_instr/if_pc hold a valid instruction.
REQ-012 if_instr  output  16  instruction at FIFO head.
REQ-013 if_pc  output  8  address of if_instr.
REQ-014 halted  output  1  fetch is in HALTED state.

Function
REQ-015 Two-entry FIFO holds {instr, pc}; head drives if_instr/if_pc; if_valid = FIFO non-empty.
REQ-016 Transfer to decode occurs when if_valid and id_ready are both 1; the head is popped on that edge.
REQ-017 Outputs SHALL hold stable while if_valid=1 and id_ready=0.
REQ-018 imem_req=1 when state=FETCH, br_taken=0, and (count + inflight - pop) < 2; no overflow ever.
REQ-019 On an edge with imem_req=1: pc <= pc+1 (8-bit wrap 8'hFF->8'h00), inflight <= 1, req_pc <= pc; else inflight <= 0.
REQ-020 On an edge with inflight=1 and no flush, {imem_rdata, req_pc} is pushed into the FIFO.
REQ-021 Simultaneous push and pop on the same edge SHALL leave count unchanged and preserve ordering.
REQ-022 br_taken=1 at edge k: FIFO cleared, inflight dropped, pc <= br_target, state <= FETCH; imem_addr=br_target in cycle k+1; if_valid=1 after edge k+2.
REQ-023 br_taken has priority over push, pop, and halt detection on the same edge.
REQ-024 States: FETCH, HALTED. FETCH->HALTED when a pushed word has opcode HALT_OPC; the halt word still enters the FIFO and is delivered.
REQ-025 In HALTED: imem_req=0 and pc frozen; exit only via br_taken (->FETCH) or reset.
REQ-026 Steady state with id_ready=1: one instruction per cycle, consecutive pc values.

Reset
REQ-027 On reset edge: pc=RESET_PC, FIFO empty, inflight=0, state=FETCH.
REQ-028 Reset values: if_valid=0, if_instr=16'h0000, if_pc=8'h00, halted=0, imem_req=0 during the reset cycle.
REQ-029 Reset SHALL override br_taken and any in-flight request; first fetch of RESET_PC occurs in the first cycle after reset deasserts.

Configuration
REQ-030 Macro FETCH_STALL_CNT_EN defined: adds output stall_cnt [15:0], incremented each cycle with if_valid=1 and id_ready=0, saturating at 16'hFFFF, cleared by reset.
REQ-031 Macro undefined: no stall_cnt port and no counter logic; all other behaviour identical.

Verification
REQ-032 Reset 2 cycles, id_ready=1, imem returns mem[a]=16'h1000+a -> if_pc 00,01,02... one per cycle, if_instr 1000,1001,1002..., first if_valid two cycles after reset release.
REQ-033 id_ready=0 for 5 cycles mid-stream -> imem_req stops after FIFO holds 2 entries, outputs stable, no instruction lost or duplicated on resume.
REQ-034 br_taken=1, br_target=8'h40 while FIFO full -> both entries flushed, next delivered if_pc=40 exactly two edges later; stale word in flight never delivered.
REQ-035 mem[03]=16'hF000 -> instructions 00..03 delivered, halted=1, imem_req=0 thereafter; br_taken to 8'h10 resumes with if_pc=10.
REQ-036 Start at pc=8'hFE (branch) -> if_pc FE, FF, 00 wrap; with FETCH_STALL_CNT_EN, 3 stalled cycles -> stall_cnt=3.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with 2-entry FIFO, branch redirect and halt (optional FETCH_STALL_CNT_EN stall counter)
module fetch_stage #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [3:0] HALT_OPC = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    output logic [7:0]  imem_addr,
    output logic        imem_req,
    input  logic [15:0] imem_rdata,
    input  logic        br_taken,
    input  logic [7:0]  br_target,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [7:0]  if_pc,
`ifdef FETCH_STALL_CNT_EN
    output logic [15:0] stall_cnt,
`endif
    output logic        halted
);

    typedef enum logic {ST_FETCH, ST_HALTED} state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  pc;
    logic        inflight;
    logic [7:0]  req_pc;
    logic [15:0] q_instr [2];
    logic [7:0]  q_pc    [2];
    logic [1:0]  count;
    logic        flush;
    logic        pop;
    logic        push;
    logic        halt_hit;
    logic [2:0]  occupancy;

    // A redirect wins over everything else on the same edge.
    assign flush     = br_taken;
    // Outputs are masked while reset is high so the reset cycle itself shows idle values.
    assign if_valid  = (count != 2'd0) && !reset;
    assign if_instr  = if_valid ? q_instr[0] : 16'h0000;
    assign if_pc     = if_valid ? q_pc[0] : 8'h00;
    assign halted    = (state == ST_HALTED) && !reset;
    assign imem_addr = pc;
    assign pop       = if_valid && id_ready && !flush;
    // A word returning after halt was detected is speculative past the halt and is dropped.
    assign push      = inflight && !flush && (state == ST_FETCH);
    assign halt_hit  = push && (imem_rdata[15:12] == HALT_OPC);
    // Slots already committed after this edge: stored entries plus the returning word minus the pop.
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign imem_req  = !reset && (state == ST_FETCH) && !br_taken && (occupancy < 3'd2);

    // Next-state: redirect resumes fetch, a pushed halt opcode stops it.
    always_comb begin
        state_next = state;
        if (br_taken) begin
            state_next = ST_FETCH;
        end else if (halt_hit) begin
            state_next = ST_HALTED;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // PC and outstanding-request tracking; req_pc tags the word returning next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            inflight <= 1'b0;
            req_pc   <= 8'h00;
        end else if (br_taken) begin
            pc       <= br_target;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pc     <= pc + 8'd1;
                req_pc <= pc;
            end
        end
    end

    // Two-entry FIFO, entry 0 is the head; simultaneous push/pop keeps the count.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    q_instr[count[0]] <= imem_rdata;
                    q_pc[count[0]]    <= req_pc;
                    count             <= count + 2'd1;
                end
                2'b01: begin
                    q_instr[0] <= q_instr[1];
                    q_pc[0]    <= q_pc[1];
                    count      <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        q_instr[0] <= imem_rdata;
                        q_pc[0]    <= req_pc;
                    end else begin
                        q_instr[0] <= q_instr[1];
                        q_pc[0]    <= q_pc[1];
                        q_instr[1] <= imem_rdata;
                        q_pc[1]    <= req_pc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FETCH_STALL_CNT_EN
    // Saturating count of cycles where decode back-pressured a valid instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 16'h0000;
        end else if (if_valid && !id_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with instruction memory and stream model
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic [15:0] imem_rdata;
    logic        br_taken;
    logic [7:0]  br_target;
    logic        id_ready;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [7:0]  if_pc;
    logic        halted;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    logic [15:0] mem [0:255];
    logic        rq;
    logic [7:0]  ra;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_rdata (imem_rdata),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .id_ready   (id_ready),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
`ifdef FETCH_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .halted     (halted)
    );

    // One clock cycle; the memory answers a request exactly one cycle later.
    task automatic tick();
        #1;
        rq = imem_req;
        ra = imem_addr;
        @(posedge clk);
        #1;
        imem_rdata = rq ? mem[ra] : 16'hBAD0;
        @(negedge clk);
        #1;
    endtask

    task automatic fill_linear();
        for (int a = 0; a < 256; a++) mem[a] = 16'h1000 + 16'(a);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        br_taken = 1'b0;
        id_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        fill_linear();
        reset = 1'b1;
        br_taken = 1'b1;
        br_target = 8'h55;
        id_ready = 1'b1;
        tick();
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid: got %0h expected 0", if_valid); end
        checks++; if (if_instr !== 16'h0000) begin errors++; $display("FAIL rst_if_instr: got %0h expected 0", if_instr); end
        checks++; if (if_pc !== 8'h00) begin errors++; $display("FAIL rst_if_pc: got %0h expected 0", if_pc); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %0h expected 0", halted); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_imem_req: got %0h expected 0", imem_req); end
        tick();
        reset = 1'b0;
        br_taken = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_first_req: got %0h expected 1", imem_req); end
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL rst_first_addr: got %0h expected 0", imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_release_valid: got %0h expected 0", if_valid); end
    endtask

    task automatic test_stream();
        fill_linear();
        do_reset();
        id_ready = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin errors++; $display("FAIL stream_c0_req: got req %0h addr %0h expected req 1 addr 0", imem_req, imem_addr); end
        tick();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stream_c1_valid: got %0h expected 0", if_valid); end
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 8'(i) || if_instr !== 16'h1000 + 16'(i)) begin
                errors++;
                $display("FAIL stream_word%0d: got v=%0h pc=%0h instr=%0h expected v=1 pc=%0h instr=%0h", i, if_valid, if_pc, if_instr, 8'(i), 16'h1000 + 16'(i));
            end
            tick();
        end
    endtask

    task automatic test_stall();
        fill_linear();
        do_reset();
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        id_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 8'h02 || if_instr !== 16'h1002) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%0h pc=%0h instr=%0h expected v=1 pc=2 instr=1002", s, if_valid, if_pc, if_instr);
            end
            if (s >= 1) begin
                checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req%0d: got %0h expected 0", s, imem_req); end
            end
            tick();
        end
        id_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 8'(2 + j) || if_instr !== 16'h1002 + 16'(j)) begin
                errors++;
                $display("FAIL stall_resume%0d: got v=%0h pc=%0h expected v=1 pc=%0h", j, if_valid, if_pc, 8'(2 + j));
            end
            tick();
        end
    endtask

    task automatic test_branch_flush();
        fill_linear();
        do_reset();
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        id_ready = 1'b0;
        tick();
        tick();
        br_taken = 1'b1;
        br_target = 8'h40;
        id_ready = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL br_req_during: got %0h expected 0", imem_req); end
        tick();
        br_taken = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL br_flush_k1: got %0h expected 0", if_valid); end
        checks++; if (imem_addr !== 8'h40 || imem_req !== 1'b1) begin errors++; $display("FAIL br_addr_k1: got addr %0h req %0h expected addr 40 req 1", imem_addr, imem_req); end
        tick();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL br_flush_k2: got %0h expected 0", if_valid); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 8'h40 || if_instr !== 16'h1040) begin errors++; $display("FAIL br_first_k3: got v=%0h pc=%0h instr=%0h expected v=1 pc=40 instr=1040", if_valid, if_pc, if_instr); end
        tick();
        checks++; if (if_pc !== 8'h41) begin errors++; $display("FAIL br_second: got %0h expected 41", if_pc); end
        br_taken = 1'b1;
        br_target = 8'h80;
        tick();
        br_taken = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL br2_flush_k1: got %0h expected 0", if_valid); end
        tick();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL br2_flush_k2: got %0h expected 0", if_valid); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 8'h80 || if_instr !== 16'h1080) begin errors++; $display("FAIL br2_first: got v=%0h pc=%0h instr=%0h expected v=1 pc=80 instr=1080", if_valid, if_pc, if_instr); end
        tick();
    endtask

    task automatic test_halt();
        logic [7:0]  got_pc [$];
        logic [15:0] got_ins [$];
        fill_linear();
        mem[3] = 16'hF000;
        do_reset();
        id_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (if_valid) begin
                got_pc.push_back(if_pc);
                got_ins.push_back(if_instr);
            end
            if (c >= 7) begin
                checks++;
                if (halted !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL halt_state_c%0d: got halted=%0h req=%0h expected halted=1 req=0", c, halted, imem_req); end
            end
            tick();
        end
        checks++; if (got_pc.size() != 4) begin errors++; $display("FAIL halt_count: got %0d expected 4", got_pc.size()); end
        if (got_pc.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_pc[i] !== 8'(i) || got_ins[i] !== mem[i]) begin errors++; $display("FAIL halt_word%0d: got pc=%0h instr=%0h expected pc=%0h instr=%0h", i, got_pc[i], got_ins[i], 8'(i), mem[i]); end
            end
        end
        br_taken = 1'b1;
        br_target = 8'h10;
        tick();
        br_taken = 1'b0;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_exit: got %0h expected 0", halted); end
        tick();
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 8'h10 || if_instr !== 16'h1010) begin errors++; $display("FAIL halt_resume: got v=%0h pc=%0h instr=%0h expected v=1 pc=10 instr=1010", if_valid, if_pc, if_instr); end
        tick();
    endtask

    task automatic test_wrap();
        fill_linear();
        do_reset();
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        br_taken = 1'b1;
        br_target = 8'hFE;
        tick();
        br_taken = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 8'(8'hFE + 8'(i)) || if_instr !== mem[8'(8'hFE + 8'(i))]) begin
                errors++;
                $display("FAIL wrap_word%0d: got v=%0h pc=%0h expected v=1 pc=%0h", i, if_valid, if_pc, 8'(8'hFE + 8'(i)));
            end
            tick();
        end
        id_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            checks++; if (if_valid !== 1'b1 || if_pc !== 8'h01) begin errors++; $display("FAIL wrap_stall%0d: got v=%0h pc=%0h expected v=1 pc=1", s, if_valid, if_pc); end
            tick();
        end
        id_ready = 1'b1;
`ifdef FETCH_STALL_CNT_EN
        checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL stall_cnt: got %0d expected 3", stall_cnt); end
        tick();
        checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL stall_cnt_hold: got %0d expected 3", stall_cnt); end
`endif
        tick();
    endtask

    task automatic test_random();
        logic [7:0]  exp_next;
        logic        prev_stall;
        logic [7:0]  prev_pc;
        logic [15:0] prev_instr;
        int          delivered;
        for (int a = 0; a < 256; a++) begin
            mem[a] = 16'($urandom);
            if (mem[a][15:12] == 4'hF) mem[a][15:12] = 4'hE;
        end
        do_reset();
        exp_next = 8'h00;
        prev_stall = 1'b0;
        prev_pc = 8'h00;
        prev_instr = 16'h0000;
        delivered = 0;
        for (int c = 0; c < 400; c++) begin
            id_ready = ($urandom_range(0, 9) < 7);
            br_taken = ($urandom_range(0, 99) < 6);
            br_target = 8'($urandom);
            #1;
            if (prev_stall) begin
                checks++;
                if (if_valid !== 1'b1 || if_pc !== prev_pc || if_instr !== prev_instr) begin
                    errors++;
                    $display("FAIL rnd_stable_c%0d: got v=%0h pc=%0h instr=%0h expected v=1 pc=%0h instr=%0h", c, if_valid, if_pc, if_instr, prev_pc, prev_instr);
                end
            end
            if (if_valid && id_ready && !br_taken) begin
                checks++;
                if (if_pc !== exp_next || if_instr !== mem[exp_next]) begin
                    errors++;
                    $display("FAIL rnd_deliver_c%0d: got pc=%0h instr=%0h expected pc=%0h instr=%0h", c, if_pc, if_instr, exp_next, mem[exp_next]);
                end
                exp_next = exp_next + 8'd1;
                delivered++;
            end
            if (br_taken) exp_next = br_target;
            prev_stall = if_valid && !id_ready && !br_taken;
            prev_pc = if_pc;
            prev_instr = if_instr;
            tick();
        end
        br_taken = 1'b0;
        checks++; if (delivered < 100) begin errors++; $display("FAIL rnd_throughput: got %0d expected at least 100", delivered); end
    endtask

    initial begin
        reset = 1'b1;
        br_taken = 1'b0;
        br_target = 8'h00;
        id_ready = 1'b0;
        imem_rdata = 16'h0000;
        @(negedge clk);
        #1;
        test_reset();
        test_stream();
        test_stall();
        test_branch_flush();
        test_halt();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
